// File: rtl/conv1d_strided.sv
// Strided, zero-padded 1-D convolution: one MAC lane per filter, one tap per cycle.
// Optional build macro CONV1D_SAT_EN: saturate on narrowing to W bits (default wraps).
module conv1d_strided #(
    parameter int IN_LEN      = 784,
    parameter int IN_CH       = 1,
    parameter int OUT_CH      = 4,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int PAD         = 0,
    parameter int OUT_LEN     = (IN_LEN + 2*PAD - KERNEL_SIZE) / STRIDE + 1,
    parameter int W           = 32
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [1:0]                            act_mode,
    input  logic [IN_LEN*IN_CH*W-1:0]             data_in,
    input  logic [OUT_CH*IN_CH*KERNEL_SIZE*W-1:0] weights,
    input  logic [OUT_CH*W-1:0]                   bias,
    output logic [OUT_LEN*OUT_CH*W-1:0]           data_out,
    output logic                                  busy,
    output logic                                  done,
    output logic [1:0]                            dbg_state
);

    localparam int TAP_COUNT = IN_CH * KERNEL_SIZE;
    localparam int AW  = W + 32;
    localparam int MW  = 2 * W;
    localparam int TW  = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
    localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int PW  = $clog2(OUT_LEN + 1);
    localparam int CHW = $clog2(IN_LEN * IN_CH + 1);
    localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, STORE, FIN} state_t;

    state_t state, state_nx;

    logic [TW-1:0]          tap_cnt;
    logic [KW-1:0]          k_cnt;
    logic [CHW-1:0]         ch_off;
    logic [PW-1:0]          pos_cnt;
    logic signed [31:0]     pos_base;
    logic [1:0]             mode_q;
    logic signed [AW-1:0]   acc       [OUT_CH];

    int                     idx;
    int                     sel;
    logic                   in_range;
    logic                   last_tap;
    logic signed [W-1:0]    operand;
    logic signed [W-1:0]    w_sel     [OUT_CH];
    logic signed [MW-1:0]   prod      [OUT_CH];
    logic signed [AW-1:0]   term      [OUT_CH];
    logic signed [AW-1:0]   sum_v     [OUT_CH];
    logic signed [AW-1:0]   act_v     [OUT_CH];
    logic [W-1:0]           store_val [OUT_CH];

    // Handshake: start is sampled only in IDLE; busy covers MAC/STORE/FIN and done
    // pulses for the single FIN cycle, so start can be accepted again one cycle later.
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign dbg_state = state;
    assign last_tap  = (tap_cnt == TW'(TAP_COUNT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MAC;
            MAC:     if (last_tap) state_nx = STORE;
            STORE:   state_nx = (pos_cnt == PW'(OUT_LEN - 1)) ? FIN : MAC;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pos_base tracks p*STRIDE-PAD so the input index needs only one add per tap.
    always_comb begin
        idx      = int'(pos_base) + int'(k_cnt);
        in_range = (idx >= 0) && (idx < IN_LEN);
        sel      = in_range ? (idx + int'(ch_off)) : 0;
        operand  = in_range ? data_in[sel*W +: W] : '0;
        for (int f = 0; f < OUT_CH; f++) begin
            w_sel[f] = weights[(f*TAP_COUNT + int'(tap_cnt))*W +: W];
            prod[f]  = MW'(operand) * MW'(w_sel[f]);
            term[f]  = AW'(prod[f] >>> 16);
        end
    end

    always_comb begin
        for (int f = 0; f < OUT_CH; f++) begin
            sum_v[f] = acc[f] + AW'($signed(bias[f*W +: W]));
            case (mode_q)
                2'd1:    act_v[f] = sum_v[f][AW-1] ? '0 : sum_v[f];
                2'd2:    act_v[f] = sum_v[f][AW-1] ? (sum_v[f] >>> 3) : sum_v[f];
                default: act_v[f] = sum_v[f];
            endcase
`ifdef CONV1D_SAT_EN
            if (act_v[f] > AW'(MAX_W))
                store_val[f] = MAX_W;
            else if (act_v[f] < AW'(MIN_W))
                store_val[f] = MIN_W;
            else
                store_val[f] = act_v[f][W-1:0];
`else
            store_val[f] = act_v[f][W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            tap_cnt  <= '0;
            k_cnt    <= '0;
            ch_off   <= '0;
            pos_cnt  <= '0;
            pos_base <= '0;
            mode_q   <= '0;
            data_out <= '0;
            for (int f = 0; f < OUT_CH; f++) acc[f] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= act_mode;
                        tap_cnt  <= '0;
                        k_cnt    <= '0;
                        ch_off   <= '0;
                        pos_cnt  <= '0;
                        pos_base <= -PAD;
                        for (int f = 0; f < OUT_CH; f++) acc[f] <= '0;
                    end
                end
                MAC: begin
                    for (int f = 0; f < OUT_CH; f++) acc[f] <= acc[f] + term[f];
                    if (last_tap) begin
                        tap_cnt <= '0;
                        k_cnt   <= '0;
                        ch_off  <= '0;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                        if (k_cnt == KW'(KERNEL_SIZE - 1)) begin
                            k_cnt  <= '0;
                            ch_off <= ch_off + CHW'(IN_LEN);
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end
                STORE: begin
                    for (int f = 0; f < OUT_CH; f++) begin
                        data_out[(f*OUT_LEN + int'(pos_cnt))*W +: W] <= store_val[f];
                        acc[f] <= '0;
                    end
                    pos_cnt  <= pos_cnt + 1'b1;
                    pos_base <= pos_base + STRIDE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_strided.sv
// Bench for conv1d_strided: two configurations (unpadded stride 1, padded stride 2)
// checked every cycle against a direct arithmetic convolution model.
module tb_conv1d_strided;

  localparam int LEN [2] = '{8, 8};
  localparam int CH  [2] = '{1, 2};
  localparam int OC  [2] = '{2, 3};
  localparam int KS  [2] = '{3, 3};
  localparam int ST  [2] = '{1, 2};
  localparam int PD  [2] = '{0, 1};
  localparam int OL  [2] = '{6, 4};

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic         start_a = 1'b0, start_b = 1'b0;
  logic [1:0]   mode_a = 2'd0, mode_b = 2'd0;
  logic [255:0] data_a = '0;
  logic [191:0] w_a = '0;
  logic [63:0]  bias_a = '0;
  logic [383:0] out_a;
  logic         busy_a, done_a;
  logic [1:0]   dbg_a;
  logic [511:0] data_b = '0;
  logic [575:0] w_b = '0;
  logic [95:0]  bias_b = '0;
  logic [383:0] out_b;
  logic         busy_b, done_b;
  logic [1:0]   dbg_b;

  int dat [2][16];
  int wts [2][18];
  int bia [2][3];
  logic [31:0] exp_out  [2][18];
  logic [31:0] exp_next [2][18];
  int rem [2] = '{0, 0};

  int checks = 0;
  int errors = 0;
  logic checking = 1'b0;

  always #5 clk = ~clk;

  conv1d_strided #(.IN_LEN(8), .IN_CH(1), .OUT_CH(2), .KERNEL_SIZE(3),
                   .STRIDE(1), .PAD(0), .W(32)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .act_mode(mode_a),
    .data_in(data_a), .weights(w_a), .bias(bias_a),
    .data_out(out_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

  conv1d_strided #(.IN_LEN(8), .IN_CH(2), .OUT_CH(3), .KERNEL_SIZE(3),
                   .STRIDE(2), .PAD(1), .W(32)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .act_mode(mode_b),
    .data_in(data_b), .weights(w_b), .bias(bias_b),
    .data_out(out_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return OL[u] * (CH[u] * KS[u] + 1) + 1;
  endfunction

  function automatic logic [31:0] get_out(input int u, input int i);
    return (u == 0) ? out_a[i*32 +: 32] : out_b[i*32 +: 32];
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_done(input int u);
    return (u == 0) ? done_a : done_b;
  endfunction

  // Direct convolution: sum of Q16.16 products over every channel/tap, padding reads zero.
  function automatic logic [31:0] model_out(input int u, input int f, input int p, input int mode);
    longint s;
    int ix;
    s = longint'(bia[u][f]);
    for (int c = 0; c < CH[u]; c++)
      for (int k = 0; k < KS[u]; k++) begin
        ix = p * ST[u] + k - PD[u];
        if (ix >= 0 && ix < LEN[u])
          s += (longint'(dat[u][c*LEN[u] + ix]) * longint'(wts[u][(f*CH[u] + c)*KS[u] + k])) >>> 16;
      end
    if (mode == 1 && s < 0) s = 0;
    else if (mode == 2 && s < 0) s = s >>> 3;
`ifdef CONV1D_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  // Run-level model: a run is accepted from idle, lasts lat_of() cycles, results appear at done.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int u = 0; u < 2; u++) begin
        rem[u] = 0;
        for (int i = 0; i < 18; i++) exp_out[u][i] = '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (rem[u] > 0) begin
          rem[u]--;
          if (rem[u] == 1)
            for (int i = 0; i < 18; i++) exp_out[u][i] = exp_next[u][i];
        end else if ((u == 0) ? start_a : start_b) begin
          rem[u] = lat_of(u);
          for (int i = 0; i < 18; i++) exp_next[u][i] = '0;
          for (int f = 0; f < OC[u]; f++)
            for (int p = 0; p < OL[u]; p++)
              exp_next[u][f*OL[u] + p] = model_out(u, f, p, (u == 0) ? int'(mode_a) : int'(mode_b));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d busy", u), 32'(get_busy(u)), 32'(rem[u] > 0));
        chk($sformatf("u%0d done", u), 32'(get_done(u)), 32'(rem[u] == 1));
        if (rem[u] <= 1)
          for (int i = 0; i < OC[u]*OL[u]; i++)
            chk($sformatf("u%0d data_out[%0d]", u, i), get_out(u, i), exp_out[u][i]);
      end
    end
  end

  task automatic pack();
    for (int i = 0; i < 8; i++)  data_a[i*32 +: 32] = dat[0][i];
    for (int i = 0; i < 6; i++)  w_a[i*32 +: 32]    = wts[0][i];
    for (int i = 0; i < 2; i++)  bias_a[i*32 +: 32] = bia[0][i];
    for (int i = 0; i < 16; i++) data_b[i*32 +: 32] = dat[1][i];
    for (int i = 0; i < 18; i++) w_b[i*32 +: 32]    = wts[1][i];
    for (int i = 0; i < 3; i++)  bias_b[i*32 +: 32] = bia[1][i];
  endtask

  task automatic run(input int u, input int mode, output int lat);
    @(negedge clk);
    pack();
    if (u == 0) begin mode_a = 2'(mode); start_a = 1'b1; end
    else        begin mode_b = 2'(mode); start_b = 1'b1; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    while (!get_done(u) && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("u%0d done_seen", u), 32'(get_done(u)), 32'd1);
    chk($sformatf("u%0d latency", u), 32'(lat), 32'(lat_of(u)));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dn;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) dat[u][i] = 0;
      for (int i = 0; i < 18; i++) wts[u][i] = 0;
      for (int i = 0; i < 3; i++)  bia[u][i] = 0;
    end
    pack();
    @(posedge clk);
    #1 checking = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy_a", 32'(busy_a), 32'd0);
    chk("reset done_b", 32'(done_b), 32'd0);
    chk("reset out_a", out_a[31:0], 32'd0);
    rstn = 1'b1;

    // Unit 0: data 1..8, unit weights, sliding sums 6..21.
    for (int i = 0; i < 8; i++) dat[0][i] = (i + 1) << 16;
    for (int i = 0; i < 6; i++) wts[0][i] = 32'h00010000;
    run(0, 0, lat);
    chk("lat_a literal", 32'(lat), 32'd25);
    for (int p = 0; p < 6; p++) chk($sformatf("a f0 p%0d", p), get_out(0, p), 32'((6 + 3*p) << 16));
    chk("a f1 p5", get_out(0, 11), 32'h00150000);

    bia[0][0] = -32'sh100000;
    bia[0][1] = -32'sh100000;
    run(0, 1, lat);
    chk("relu p0", get_out(0, 0), 32'h0);
    chk("relu p3", get_out(0, 3), 32'h0);
    chk("relu p4", get_out(0, 4), 32'h00020000);
    run(0, 2, lat);
    chk("leaky p0", get_out(0, 0), 32'hFFFEC000);
    chk("leaky p1", get_out(0, 1), 32'hFFFF2000);
    chk("leaky p5", get_out(0, 5), 32'h00050000);

    // Unit 1: stride 2, pad 1, channel 1 weights zero on filter 0.
    for (int i = 0; i < 8; i++)  dat[1][i] = (i + 1) << 16;
    for (int i = 8; i < 16; i++) dat[1][i] = int'($urandom_range(0, 32'h000FFFFF));
    for (int i = 0; i < 3; i++)  wts[1][i] = 32'h00010000;
    for (int i = 3; i < 6; i++)  wts[1][i] = 0;
    for (int i = 6; i < 18; i++) wts[1][i] = int'($urandom_range(0, 32'h0003FFFF)) - 32'sh20000;
    bia[1][1] = 32'sh8000;
    bia[1][2] = -32'sh18000;
    run(1, 0, lat);
    chk("lat_b literal", 32'(lat), 32'd29);
    for (int p = 0; p < 4; p++) chk($sformatf("b f0 p%0d", p), get_out(1, p), 32'((3 + 6*p) << 16));

    // Full-scale operands: saturation vs wrap.
    for (int i = 0; i < 8; i++) dat[0][i] = 32'h7FFF0000;
    for (int i = 0; i < 6; i++) wts[0][i] = 32'h7FFF0000;
    bia[0][0] = 0;
    bia[0][1] = 0;
    run(0, 0, lat);
`ifdef CONV1D_SAT_EN
    chk("big p0", get_out(0, 0), 32'h7FFFFFFF);
    chk("big f1 p5", get_out(0, 11), 32'h7FFFFFFF);
`else
    chk("big p0", get_out(0, 0), 32'h00030000);
    chk("big f1 p5", get_out(0, 11), 32'h00030000);
`endif

    // Reset in the middle of position 2.
    for (int i = 0; i < 8; i++) dat[0][i] = (i + 1) << 16;
    for (int i = 0; i < 6; i++) wts[0][i] = 32'h00010000;
    @(negedge clk);
    pack();
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy", 32'(busy_a), 32'd0);
    chk("midrst out0", out_a[31:0], 32'd0);
    chk("midrst out_b", out_b[95:64], 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run(0, 0, lat);
    chk("post-reset p2", get_out(0, 2), 32'h000C0000);

    // Start held high: one run per idle entry.
    @(negedge clk);
    start_a = 1'b1;
    mode_a = 2'd0;
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done_a) dn++;
      if (i == 59) start_a = 1'b0;
    end
    chk("held runs", 32'(dn), 32'd3);

    // Randomized runs on both units.
    for (int it = 0; it < 10; it++) begin
      int u;
      u = it % 2;
      for (int i = 0; i < 16; i++) dat[u][i] = int'($urandom);
      for (int i = 0; i < 18; i++) wts[u][i] = int'($urandom);
      for (int i = 0; i < 3; i++)  bia[u][i] = int'($urandom);
      if (it >= 6)
        for (int i = 0; i < 16; i++) dat[u][i] = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh40000;
      run(u, int'($urandom_range(0, 3)), lat);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
